// File: rtl/aes_msg_seq.sv
// Multi-block message sequencer for aes_core: one key expansion per message,
// one core_next per block, with ECB/CBC chaining done locally around an ECB-only core.
//
// state    | meaning
// IDLE     | waiting for start; configuration is latched on acceptance
// KEY      | waiting for the core to be ready before pulsing core_init
// KEY_WAIT | guard cycle, then wait for key expansion to finish
// IN       | accepting one input block
// NEXT     | waiting for the core to be ready before pulsing core_next
// RES_WAIT | guard cycle, then wait for the core result
// OUT      | presenting the result until it is taken
// DONE     | one-cycle end-of-message pulse
module aes_msg_seq #(
    parameter int BIT_LENGTH = 256,
    parameter int SIZE_BLOCK = 128,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  ecb_cbc,
    input  logic                  encdec,
    input  logic                  keylen,
    input  logic [BIT_LENGTH-1:0] key,
    input  logic [SIZE_BLOCK-1:0] iv,
    input  logic [CNT_W-1:0]      n_blocks,
    input  logic                  in_valid,
    input  logic [SIZE_BLOCK-1:0] in_block,
    output logic                  in_ready,
    output logic                  out_valid,
    output logic [SIZE_BLOCK-1:0] out_block,
    input  logic                  out_ready,
    output logic                  busy,
    output logic                  done,
    output logic                  core_init,
    output logic                  core_next,
    output logic                  core_ecb_cbc,
    output logic                  core_encdec,
    output logic                  core_keylen,
    output logic [BIT_LENGTH-1:0] core_key,
    output logic [SIZE_BLOCK-1:0] core_iv,
    output logic [SIZE_BLOCK-1:0] core_block,
    input  logic                  core_ready,
    input  logic                  core_result_valid,
    input  logic [SIZE_BLOCK-1:0] core_result
);

    typedef enum logic [2:0] {
        S_IDLE, S_KEY, S_KEY_WAIT, S_IN, S_NEXT, S_RES_WAIT, S_OUT, S_DONE
    } state_t;

    state_t                state_q, state_d;
    logic                  guard_q, guard_d;
    logic                  cbc_q, cbc_d;
    logic                  encdec_q, encdec_d;
    logic                  keylen_q, keylen_d;
    logic [BIT_LENGTH-1:0] key_q, key_d;
    logic [SIZE_BLOCK-1:0] chain_q, chain_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [SIZE_BLOCK-1:0] ct_in_q, ct_in_d;
    logic [SIZE_BLOCK-1:0] core_block_q, core_block_d;
    logic [SIZE_BLOCK-1:0] out_block_q, out_block_d;
    logic                  core_init_q, core_init_d;
    logic                  core_next_q, core_next_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            guard_q      <= 1'b0;
            cbc_q        <= 1'b0;
            encdec_q     <= 1'b0;
            keylen_q     <= 1'b0;
            key_q        <= '0;
            chain_q      <= '0;
            cnt_q        <= '0;
            ct_in_q      <= '0;
            core_block_q <= '0;
            out_block_q  <= '0;
            core_init_q  <= 1'b0;
            core_next_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            guard_q      <= guard_d;
            cbc_q        <= cbc_d;
            encdec_q     <= encdec_d;
            keylen_q     <= keylen_d;
            key_q        <= key_d;
            chain_q      <= chain_d;
            cnt_q        <= cnt_d;
            ct_in_q      <= ct_in_d;
            core_block_q <= core_block_d;
            out_block_q  <= out_block_d;
            core_init_q  <= core_init_d;
            core_next_q  <= core_next_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        guard_d      = 1'b0;
        cbc_d        = cbc_q;
        encdec_d     = encdec_q;
        keylen_d     = keylen_q;
        key_d        = key_q;
        chain_d      = chain_q;
        cnt_d        = cnt_q;
        ct_in_d      = ct_in_q;
        core_block_d = core_block_q;
        out_block_d  = out_block_q;
        core_init_d  = 1'b0;
        core_next_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    cbc_d    = ecb_cbc;
                    encdec_d = encdec;
                    keylen_d = keylen;
                    key_d    = key;
                    chain_d  = iv;
                    cnt_d    = n_blocks;
                    state_d  = (n_blocks == '0) ? S_DONE : S_KEY;
                end
            end
            S_KEY: begin
                if (core_ready) begin
                    core_init_d = 1'b1;
                    guard_d     = 1'b1;
                    state_d     = S_KEY_WAIT;
                end
            end
            S_KEY_WAIT: begin
                // core_ready still shows the pre-init status during the guard cycle
                if (!guard_q && core_ready) begin
                    state_d = S_IN;
                end
            end
            S_IN: begin
                if (in_valid) begin
                    ct_in_d      = in_block;
                    core_block_d = in_block ^ ({SIZE_BLOCK{cbc_q & encdec_q}} & chain_q);
                    state_d      = S_NEXT;
                end
            end
            S_NEXT: begin
                if (core_ready) begin
                    core_next_d = 1'b1;
                    guard_d     = 1'b1;
                    state_d     = S_RES_WAIT;
                end
            end
            S_RES_WAIT: begin
                // the previous block's result_valid is still visible during the guard cycle
                if (!guard_q && core_ready && core_result_valid) begin
                    if (cbc_q && !encdec_q) begin
                        out_block_d = core_result ^ chain_q;
                        chain_d     = ct_in_q;
                    end else begin
                        out_block_d = core_result;
                        if (cbc_q) begin
                            chain_d = core_result;
                        end
                    end
                    cnt_d   = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
                    state_d = S_OUT;
                end
            end
            S_OUT: begin
                if (out_ready) begin
                    state_d = (cnt_q == '0) ? S_DONE : S_IN;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign in_ready     = (state_q == S_IN);
    assign out_valid    = (state_q == S_OUT);
    assign done         = (state_q == S_DONE);
    assign busy         = (state_q != S_IDLE);
    assign out_block    = out_block_q;
    assign core_init    = core_init_q;
    assign core_next    = core_next_q;
    assign core_ecb_cbc = 1'b0;
    assign core_encdec  = encdec_q;
    assign core_keylen  = keylen_q;
    assign core_key     = key_q;
    assign core_iv      = '0;
    assign core_block   = core_block_q;

endmodule

// File: tb/tb_aes_msg_seq.sv
// Self-checking bench for aes_msg_seq: a keyed toy block cipher stands in for aes_core,
// and expected message outputs come from ECB/CBC chaining rules applied to whole blocks.
module tb_aes_msg_seq;

    logic         clk = 1'b0;
    logic         rst;
    logic         start, ecb_cbc, encdec, keylen;
    logic [255:0] key;
    logic [127:0] iv;
    logic [15:0]  n_blocks;
    logic         in_valid;
    logic [127:0] in_block;
    logic         in_ready, out_valid;
    logic [127:0] out_block;
    logic         out_ready, busy, done;
    logic         core_init, core_next, core_ecb_cbc, core_encdec, core_keylen;
    logic [255:0] core_key;
    logic [127:0] core_iv, core_block;
    logic         core_ready, core_result_valid;
    logic [127:0] core_result;

    aes_msg_seq #(.BIT_LENGTH(256), .SIZE_BLOCK(128), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .start(start), .ecb_cbc(ecb_cbc), .encdec(encdec),
        .keylen(keylen), .key(key), .iv(iv), .n_blocks(n_blocks),
        .in_valid(in_valid), .in_block(in_block), .in_ready(in_ready),
        .out_valid(out_valid), .out_block(out_block), .out_ready(out_ready),
        .busy(busy), .done(done), .core_init(core_init), .core_next(core_next),
        .core_ecb_cbc(core_ecb_cbc), .core_encdec(core_encdec), .core_keylen(core_keylen),
        .core_key(core_key), .core_iv(core_iv), .core_block(core_block),
        .core_ready(core_ready), .core_result_valid(core_result_valid),
        .core_result(core_result)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [127:0] rotl13(input logic [127:0] x);
        return {x[114:0], x[127:115]};
    endfunction

    function automatic logic [127:0] rotr13(input logic [127:0] x);
        return {x[12:0], x[127:13]};
    endfunction

    // Invertible keyed stand-in for AES; keylen selects whether the lower key half is used.
    function automatic logic [127:0] toy(input logic enc, input logic kl,
                                         input logic [255:0] k, input logic [127:0] x);
        logic [127:0] k0, k1;
        k0 = k[255:128];
        k1 = kl ? k[127:0] : 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
        if (enc) return rotl13(x ^ k0) + k1;
        return rotr13(x - k1) ^ k0;
    endfunction

    // Core model: ready drops after init/next, result appears after a random latency.
    logic [255:0] m_key;
    logic         m_kl;
    logic         m_key_done;
    int           m_lat;
    logic         m_pend;
    logic [127:0] m_res;

    always @(posedge clk) begin
        if (rst) begin
            core_ready        <= 1'b1;
            core_result_valid <= 1'b0;
            core_result       <= '0;
            m_lat             <= 0;
            m_pend            <= 1'b0;
            m_key_done        <= 1'b0;
            m_key             <= '0;
            m_kl              <= 1'b0;
            m_res             <= '0;
        end else if (m_lat > 0) begin
            m_lat <= m_lat - 1;
            if (m_lat == 1) begin
                core_ready <= 1'b1;
                if (m_pend) begin
                    core_result_valid <= 1'b1;
                    core_result       <= m_res;
                end else begin
                    m_key_done <= 1'b1;
                end
            end
        end else if (core_init) begin
            core_ready        <= 1'b0;
            core_result_valid <= 1'b0;
            m_lat             <= $urandom_range(2, 6);
            m_pend            <= 1'b0;
            m_key_done        <= 1'b0;
            m_key             <= core_key;
            m_kl              <= core_keylen;
        end else if (core_next) begin
            core_ready        <= 1'b0;
            core_result_valid <= 1'b0;
            m_lat             <= $urandom_range(1, 6);
            m_pend            <= 1'b1;
            m_res             <= toy(core_encdec, m_kl, m_key, core_block);
        end
    end

    logic [127:0] blocks[$];
    logic [127:0] got[$];

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_ctl"}, {in_ready, out_valid, busy, done, core_init, core_next,
                            core_encdec, core_keylen}, 8'h00);
        chk({tag, "_out_block"}, out_block, 0);
        chk({tag, "_core_block"}, core_block, 0);
        chk({tag, "_core_key"}, core_key, 0);
    endtask

    task automatic run_msg(input logic cbc, input logic enc, input logic kl,
                           input logic [255:0] key_v, input logic [127:0] iv_v,
                           input int n, input int stall_cycles, input int abort_after);
        logic [127:0] exp[$];
        logic [127:0] c, y, held;
        int in_i, out_i, inits, nexts, dones, cyc, stall_left, budget;
        int init_cyc, done_cyc, stall_bad, overlap, proto_bad;
        bit seen_done, holding, first_in;

        got.delete();
        while (blocks.size() < n) blocks.push_back({$urandom, $urandom, $urandom, $urandom});
        c = iv_v;
        for (int i = 0; i < n; i++) begin
            if (!cbc) begin
                y = toy(enc, kl, key_v, blocks[i]);
            end else if (enc) begin
                y = toy(1'b1, kl, key_v, blocks[i] ^ c);
                c = y;
            end else begin
                y = toy(1'b0, kl, key_v, blocks[i]) ^ c;
                c = blocks[i];
            end
            exp.push_back(y);
        end

        ecb_cbc = cbc; encdec = enc; keylen = kl; key = key_v; iv = iv_v;
        n_blocks = 16'(n); start = 1'b1;
        step();
        chk("busy_rise", busy, 1);
        chk("cfg_latch", {core_key, core_encdec, core_keylen, core_ecb_cbc},
            {key_v, enc, kl, 1'b0});

        in_i = 0; out_i = 0; inits = 0; nexts = 0; dones = 0; cyc = 0;
        init_cyc = -1; done_cyc = -1; stall_bad = 0; overlap = 0; proto_bad = 0;
        seen_done = 0; holding = 0; first_in = 1; stall_left = stall_cycles;
        budget = 100 + n * (stall_cycles + 60);
        while (!seen_done && cyc < budget) begin
            start    = ($urandom_range(0, 3) == 0);
            ecb_cbc  = 1'($urandom); encdec = 1'($urandom); keylen = 1'($urandom);
            key      = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            iv       = {$urandom, $urandom, $urandom, $urandom};
            n_blocks = 16'($urandom);
            in_valid = (in_i < n) && ($urandom_range(0, 2) != 0);
            in_block = in_valid ? blocks[in_i] : {$urandom, $urandom, $urandom, $urandom};
            out_ready = (stall_left > 0) ? 1'b0 : ($urandom_range(0, 3) != 0);

            if (core_init) begin
                inits++;
                if (init_cyc < 0) init_cyc = cyc;
                if (!core_ready) proto_bad++;
            end
            if (core_next) begin
                nexts++;
                if (!core_ready || !m_key_done) proto_bad++;
                if (out_valid && !out_ready) proto_bad++;
            end
            if (in_ready && first_in) begin
                chk("key_before_in", m_key_done, 1);
                first_in = 0;
            end
            if (done) begin
                dones++;
                done_cyc  = cyc;
                seen_done = 1;
            end
            if (done && out_valid) overlap++;
            if (in_valid && in_ready) in_i++;
            if (out_valid && out_ready) begin
                if (holding && out_block !== held) stall_bad++;
                if (out_i < n) chk("out_block", out_block, exp[out_i]);
                else chk("extra_output", 1, 0);
                got.push_back(out_block);
                out_i++;
                holding = 0;
            end else if (out_valid) begin
                if (holding && out_block !== held) stall_bad++;
                held    = out_block;
                holding = 1;
                if (stall_left > 0) stall_left--;
            end
            step();
            cyc++;
            if (abort_after > 0 && out_i == abort_after && !(out_valid && !out_ready)) begin
                rst = 1'b1; start = 1'b0; in_valid = 1'b0;
                step();
                check_reset_outputs("abort");
                rst = 1'b0;
                blocks.delete();
                return;
            end
        end
        start = 1'b0; in_valid = 1'b0;

        chk("done_seen", seen_done, 1);
        chk("busy_fall", busy, 0);
        chk("n_out", out_i, n);
        chk("n_init", inits, (n == 0) ? 0 : 1);
        chk("n_next", nexts, n);
        chk("done_once", dones, 1);
        chk("stall_stable", stall_bad, 0);
        chk("done_out_overlap", overlap, 0);
        chk("core_protocol", proto_bad, 0);
        if (n == 0) chk("zero_done_fast", done_cyc <= 1, 1);
        else chk("init_latency", init_cyc, 1);
        if (!seen_done) begin
            rst = 1'b1;
            step();
            rst = 1'b0;
        end
        blocks.delete();
    endtask

    logic [127:0] pts[$];
    logic [127:0] cts[$];
    logic [255:0] k_v;

    initial begin
        rst = 1'b1; start = 1'b0; ecb_cbc = 1'b0; encdec = 1'b0; keylen = 1'b0;
        key = '0; iv = '0; n_blocks = '0; in_valid = 1'b0; in_block = '0; out_ready = 1'b0;
        repeat (3) step();
        check_reset_outputs("reset");
        chk("core_tieoffs", {core_ecb_cbc, core_iv}, 0);
        rst = 1'b0;
        step();

        // single-block ECB encrypt, 128-bit key in the upper key half
        blocks.push_back(128'h00112233445566778899aabbccddeeff);
        run_msg(1'b0, 1'b1, 1'b0, {128'h000102030405060708090a0b0c0d0e0f, 128'h0},
                128'h0, 1, 0, 0);

        // two-block CBC encrypt, then decrypt of its output must restore the plaintexts
        k_v = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
        pts.push_back(128'h6bc1bee22e409f96e93d7e117393172a);
        pts.push_back(128'hae2d8a571e03ac9c9eb76fac45af8e51);
        foreach (pts[i]) blocks.push_back(pts[i]);
        run_msg(1'b1, 1'b1, 1'b0, k_v, 128'h000102030405060708090a0b0c0d0e0f, 2, 0, 0);
        foreach (got[i]) cts.push_back(got[i]);
        foreach (cts[i]) blocks.push_back(cts[i]);
        run_msg(1'b1, 1'b0, 1'b0, k_v, 128'h000102030405060708090a0b0c0d0e0f, 2, 0, 0);
        chk("cbc_roundtrip_0", got[0], pts[0]);
        chk("cbc_roundtrip_1", got[1], pts[1]);

        // back-pressure with a 20-cycle output stall and random input bubbles
        run_msg(1'b0, 1'b1, 1'b1, {$urandom, $urandom, $urandom, $urandom,
                $urandom, $urandom, $urandom, $urandom}, 128'h0, 4, 20, 0);

        // empty message
        run_msg(1'b0, 1'b1, 1'b0, 256'h0, 128'h0, 0, 0, 0);

        // reset after the first of three blocks, then a clean single-block message
        run_msg(1'b1, 1'b1, 1'b1, {8{32'hdeadbeef}}, 128'h1234, 3, 0, 1);
        blocks.push_back(128'h00112233445566778899aabbccddeeff);
        run_msg(1'b0, 1'b1, 1'b0, {128'h000102030405060708090a0b0c0d0e0f, 128'h0},
                128'h0, 1, 0, 0);

        // random messages across all modes
        for (int m = 0; m < 8; m++) begin
            run_msg(1'($urandom), 1'($urandom), 1'($urandom),
                    {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom},
                    {$urandom, $urandom, $urandom, $urandom},
                    $urandom_range(1, 6), $urandom_range(0, 5), 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/aes_msg_seq.md
# aes_msg_seq

Multi-block message sequencer for `aes_core`. It takes a message configuration plus a stream of 128-bit blocks and issues key expansion once per message. It then pulses `next` once per block, honouring the core's `ready`/`result_valid` handshake. CBC chaining is done locally, so the core always runs in ECB mode. The block sits between the register interface (SIPO/PISO) and `aes_core`, replacing direct software toggling of `init`/`next`.

## Interface

Parameters:
- `BIT_LENGTH`, 256: key width.
- `SIZE_BLOCK`, 128: block width.
- `CNT_W`, 16: width of the block counter.

Ports (name, direction, width, meaning):
- `clk` in 1: single clock; all logic is on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: one-cycle message start; sampled only in IDLE.
- `ecb_cbc` in 1: 0 = ECB, 1 = CBC; latched at `start`.
- `encdec` in 1: 1 = encrypt, 0 = decrypt; latched at `start`.
- `keylen` in 1: 0 = 128-bit, 1 = 256-bit; latched at `start`.
- `key` in BIT_LENGTH: latched at `start`.
- `iv` in SIZE_BLOCK: initial chaining value; latched at `start`.
- `n_blocks` in CNT_W: number of blocks in the message; latched at `start`.
- `in_valid`, `in_block` in 1 / SIZE_BLOCK: input block stream.
- `in_ready` out 1: input handshake.
- `out_valid`, `out_block` out 1 / SIZE_BLOCK: result stream.
- `out_ready` in 1: result handshake.
- `busy` out 1: high from `start` acceptance until DONE exits.
- `done` out 1: one-cycle pulse at message end.
- `core_init`, `core_next` out 1: one-cycle pulses to `aes_core`.
- `core_ecb_cbc` out 1: tied to 0 (ECB).
- `core_encdec`, `core_keylen` out 1: driven from the latched configuration.
- `core_key` out BIT_LENGTH, `core_iv` out SIZE_BLOCK, `core_block` out SIZE_BLOCK: core data inputs; `core_iv` is tied to 0.
- `core_ready`, `core_result_valid` in 1: core status.
- `core_result` in SIZE_BLOCK: core output.

## Operation

State machine: IDLE → KEY → KEY_WAIT → IN → NEXT → RES_WAIT → OUT → (IN | DONE) → IDLE.

- **IDLE.** On `start`=1, latch the configuration and set `chain`=`iv`, `cnt`=`n_blocks`.
  - If `n_blocks`=0, go directly to DONE.
  - Otherwise go to KEY.
- **KEY.**
  - Wait for `core_ready`=1.
  - Then assert `core_init` for 1 cycle and go to KEY_WAIT.
- **KEY_WAIT.**
  - Guard cycle first: `core_ready` is ignored in the first cycle after the pulse.
  - After the guard cycle, go to IN when `core_ready`=1.
- **IN.** `in_ready`=1. On `in_valid`&&`in_ready`, register `blk` and `ct_in`=`in_block`, then go to NEXT.
- **NEXT.**
  - Wait for `core_ready`=1.
  - Pulse `core_next` for 1 cycle, with `core_block` = `blk` XOR (`chain` if CBC-encrypt, else 0).
  - Go to RES_WAIT.
  - `core_block` is held stable from NEXT until RES_WAIT exits.
- **RES_WAIT.**
  - Guard cycle first.
  - After the guard cycle, wait for `core_ready`=1 and `core_result_valid`=1.
  - Then register `out_block`:
    - CBC-decrypt: `core_result` XOR `chain`.
    - Otherwise: `core_result`.
  - Update `chain`:
    - CBC-encrypt: `core_result`.
    - CBC-decrypt: `ct_in`.
    - ECB: unchanged.
  - Decrement `cnt`, then go to OUT.
- **OUT.**
  - `out_valid`=1; `out_block` is held until `out_valid`&&`out_ready`.
  - On that transfer, go to DONE if `cnt`=0, else to IN.
- **DONE.** `done`=1 for 1 cycle, `busy`=0 in the next cycle, return to IDLE.

Rules:
- `start` outside IDLE is ignored.
- Key expansion is never repeated within a message.
- Inputs that are not latched are don't-care outside their handshake.

## Timing

- Reset values:
  - `in_ready`, `out_valid`, `busy`, `done`, `core_init`, `core_next` = 0.
  - `out_block`, `core_block`, `core_key` = 0.
  - `core_encdec`, `core_keylen` = 0.
  - State = IDLE; internal registers cleared.
- `rst` mid-message aborts immediately. The core is not drained; the next `start` re-runs key expansion.
- `busy` rises in the cycle after `start` is accepted.
- `core_init` rises the cycle after KEY is entered if `core_ready` is already 1.
- Per-block overhead around core latency (input transfer to `out_valid`) is 2 + core latency + 1 cycles.
- Back-to-back throughput: a new block is accepted in the cycle after the OUT transfer.
- `out_ready` held low stalls the sequence indefinitely; no data is lost and the core stays idle.
- `cnt` never wraps: `n_blocks`=2^CNT_W−1 processes exactly that many blocks.
- `done` and `out_valid` are never high in the same cycle.

## Test plan

- **FIPS-197 ECB encrypt.** Key 000102…0f, 128-bit, `n_blocks`=1, pt 00112233445566778899aabbccddeeff → `out_block` 69c4e0d86a7b0430d8cdb78070b4c55a, then `done` pulses once and `core_init` has pulsed exactly once.
- **SP800-38A CBC encrypt.** Key 2b7e151628aed2a6abf7158809cf4f3c, IV 000102…0f, pts 6bc1bee22e409f96e93d7e117393172a, ae2d8a571e03ac9c9eb76fac45af8e51 → 7649abac8119b246cee98e9b12e9197d, 5086cb9b507219ee95db113a917678b2.
- **CBC decrypt.** Same key and IV, feed those two ciphertexts → the original two plaintexts, in order.
- **Back-pressure and bubbles.** `out_ready`=0 for 20 cycles with random `in_valid` gaps, 4 ECB blocks → `out_block` stable while stalled, exactly 4 outputs, no `core_next` issued while OUT is stalled.
- **Boundary: `n_blocks`=0.** `start` → `done` pulses within 2 cycles, no `core_init` or `core_next`. A `start` while `busy` is ignored.
- **Reset mid-message.** `rst` after block 1 of 3 → all outputs reach their reset values the next cycle; a fresh 1-block ECB message then yields the correct ciphertext.
